vga_tile_renderer: RTL and testbench



---
 rtl/vga_tile_renderer.sv | 131 +++++++++++++
 tb/tb_vga_tile_renderer.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/vga_tile_renderer.sv
// vga_tile_renderer: turns vga_ctrl pixel positions into RGB by looking up the
// Sokoban map tile (map RAM) and then the texel (sprite ROM).
// Five-register pipeline: map_addr, map RAM, sprite_addr, sprite ROM, RGB.
// hsync/vsync/vga_blank_z are delayed by the same five registers.
// Optional build macro VGA_TILE_GRID_EN draws a white 1-pixel tile grid.
module vga_tile_renderer #(
    parameter int TILE_BITS = 5,
    parameter int MAP_W     = 20,
    parameter int MAP_H     = 15,
    parameter int IDX_W     = 3,
    parameter int POS_W     = 11,
    parameter int MAP_AW    = 9
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic [POS_W-1:0]             x_pos,
    input  logic [POS_W-1:0]             y_pos,
    input  logic                         in_hsync,
    input  logic                         in_vsync,
    input  logic                         in_blank_z,
    output logic [MAP_AW-1:0]            map_addr,
    input  logic [IDX_W-1:0]             map_data,
    output logic [IDX_W+2*TILE_BITS-1:0] sprite_addr,
    input  logic [11:0]                  sprite_data,
    output logic                         hsync,
    output logic                         vsync,
    output logic                         vga_blank_z,
    output logic [7:0]                   red,
    output logic [7:0]                   green,
    output logic [7:0]                   blue
);
    localparam int STAGES = 5;
    localparam logic [POS_W-1:0] MAP_XMAX = POS_W'(MAP_W << TILE_BITS);
    localparam logic [POS_W-1:0] MAP_YMAX = POS_W'(MAP_H << TILE_BITS);

    // Sync/blank delay lines; bit STAGES-1 is the output tap.
    logic [STAGES-1:0] hs_sr, vs_sr, bz_sr;
    // in_map flag travelling with each pixel through stages 1..4.
    logic [4:1] in_map_pipe;
    // Texel offsets inside the tile (col = x, row = y).
    logic [TILE_BITS-1:0] col1, row1, col2, row2;
`ifdef VGA_TILE_GRID_EN
    logic [TILE_BITS-1:0] col3, row3, col4, row4;
    logic                 grid_hit;
`endif
    logic in_map0;

    assign in_map0 = in_blank_z & (x_pos < MAP_XMAX) & (y_pos < MAP_YMAX);

    // Stages 1-4: address generation and carrying per-pixel side data.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            map_addr    <= '0;
            sprite_addr <= '0;
            in_map_pipe <= '0;
            col1        <= '0;
            row1        <= '0;
            col2        <= '0;
            row2        <= '0;
        end else begin
            // Constant multiply by MAP_W; synthesis folds it to shifts/adds.
            map_addr    <= MAP_AW'(32'(y_pos >> TILE_BITS) * 32'(MAP_W)
                                   + 32'(x_pos >> TILE_BITS));
            col1        <= x_pos[TILE_BITS-1:0];
            row1        <= y_pos[TILE_BITS-1:0];
            col2        <= col1;
            row2        <= row1;
            sprite_addr <= {map_data, row2, col2};
            in_map_pipe <= {in_map_pipe[3:1], in_map0};
        end
    end

`ifdef VGA_TILE_GRID_EN
    // Offsets follow the pixel to stage 4 so the grid test uses its own position.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            col3 <= '0;
            row3 <= '0;
            col4 <= '0;
            row4 <= '0;
        end else begin
            col3 <= col2;
            row3 <= row2;
            col4 <= col3;
            row4 <= row3;
        end
    end
    assign grid_hit = (col4 == '0) | (row4 == '0);
`endif

    // Stage 5: expand RGB444 to RGB888 by nibble replication; black outside map.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            red   <= 8'h00;
            green <= 8'h00;
            blue  <= 8'h00;
        end else if (!in_map_pipe[4]) begin
            red   <= 8'h00;
            green <= 8'h00;
            blue  <= 8'h00;
`ifdef VGA_TILE_GRID_EN
        end else if (grid_hit) begin
            red   <= 8'hFF;
            green <= 8'hFF;
            blue  <= 8'hFF;
`endif
        end else begin
            red   <= {2{sprite_data[11:8]}};
            green <= {2{sprite_data[7:4]}};
            blue  <= {2{sprite_data[3:0]}};
        end
    end

    // Sync and blank delay lines, idle = syncs high, blanked.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            hs_sr <= '1;
            vs_sr <= '1;
            bz_sr <= '0;
        end else begin
            hs_sr <= {hs_sr[STAGES-2:0], in_hsync};
            vs_sr <= {vs_sr[STAGES-2:0], in_vsync};
            bz_sr <= {bz_sr[STAGES-2:0], in_blank_z};
        end
    end

    assign hsync       = hs_sr[STAGES-1];
    assign vsync       = vs_sr[STAGES-1];
    assign vga_blank_z = bz_sr[STAGES-1];

endmodule

// File: tb/tb_vga_tile_renderer.sv
// Testbench for vga_tile_renderer: map RAM / sprite ROM models, a per-pixel
// reference computed from tile arithmetic, directed table and random stimulus.
module tb_vga_tile_renderer;
    localparam int NH = 4096;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [10:0] x_pos, y_pos;
    logic        in_hsync, in_vsync, in_blank_z;
    logic [8:0]  map_addr;
    logic [2:0]  map_data;
    logic [12:0] sprite_addr;
    logic [11:0] sprite_data;
    logic        hsync, vsync, vga_blank_z;
    logic [7:0]  red, green, blue;

    always #5 clk = ~clk;

    vga_tile_renderer dut (
        .clk(clk), .reset_n(reset_n), .x_pos(x_pos), .y_pos(y_pos),
        .in_hsync(in_hsync), .in_vsync(in_vsync), .in_blank_z(in_blank_z),
        .map_addr(map_addr), .map_data(map_data),
        .sprite_addr(sprite_addr), .sprite_data(sprite_data),
        .hsync(hsync), .vsync(vsync), .vga_blank_z(vga_blank_z),
        .red(red), .green(green), .blue(blue)
    );

    logic [2:0]  map_mem [0:511];
    logic [11:0] rom     [0:8191];

    // Registered-read memory models.
    always @(posedge clk) begin
        map_data    <= map_mem[map_addr];
        sprite_data <= rom[sprite_addr];
    end

    int n_chk = 0;
    int n_fail = 0;
    int e = 0;
    int hx [0:NH-1];
    int hy [0:NH-1];
    bit hhs[0:NH-1], hvs[0:NH-1], hbz[0:NH-1], hrst[0:NH-1];

    typedef struct {
        int          x;
        int          y;
        bit          bz;
        logic [23:0] rgb;
    } vec_t;
    vec_t tbl [7];

    // Expected {hsync, vsync, blank_z, rgb} after capture edge m.
    function automatic logic [26:0] expect_at(int m);
        int x, y, tile, tex_i;
        logic [11:0] tex;
        logic [23:0] rgb;
        if (m <= 4) return {3'b110, 24'h0};
        for (int k = m - 4; k <= m; k++)
            if (hrst[k]) return {3'b110, 24'h0};
        x = hx[m-4];
        y = hy[m-4];
        rgb = 24'h0;
        if (hbz[m-4] && x < 640 && y < 480) begin
            tile  = int'(map_mem[(y / 32) * 20 + x / 32]);
            tex_i = tile * 1024 + (y % 32) * 32 + (x % 32);
            tex   = rom[tex_i];
            rgb   = {tex[11:8], tex[11:8], tex[7:4], tex[7:4], tex[3:0], tex[3:0]};
`ifdef VGA_TILE_GRID_EN
            if (x % 32 == 0 || y % 32 == 0) rgb = 24'hFFFFFF;
`endif
        end
        return {hhs[m-4], hvs[m-4], hbz[m-4], rgb};
    endfunction

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at edge %0d: got %h expected %h", nm, e, got, exp);
        end
    endtask

    // Drive one pixel, let it be captured, then check the output against the model.
    task automatic cycle(input bit rst, input int x, input int y,
                         input bit hs, input bit vs, input bit bz);
        reset_n    = ~rst;
        x_pos      = 11'(x);
        y_pos      = 11'(y);
        in_hsync   = hs;
        in_vsync   = vs;
        in_blank_z = bz;
        @(posedge clk);
        e++;
        hx[e] = x; hy[e] = y; hhs[e] = hs; hvs[e] = vs; hbz[e] = bz; hrst[e] = rst;
        @(negedge clk);
        check("pixel", {5'b0, hsync, vsync, vga_blank_z, red, green, blue},
              {5'b0, expect_at(e)});
    endtask

    task automatic idle_cycle();
        cycle(1'b0, 0, 0, 1'b1, 1'b1, 1'b0);
    endtask

    bit hs_pat [0:11];
    bit vs_pat [0:11];

    initial begin
        for (int i = 0; i < 512; i++)  map_mem[i] = 3'($urandom);
        for (int i = 0; i < 8192; i++) rom[i] = 12'($urandom);
        map_mem[41]  = 3'd3; rom[13'hCC5]  = 12'hF80;
        map_mem[299] = 3'd7; rom[7*1024+31*32+31] = 12'hA5C;
        map_mem[22]  = 3'd5; rom[5*1024+8*32] = 12'h123;

        tbl[0] = '{37,  70,  1'b1, 24'hFF8800};
        tbl[1] = '{640, 10,  1'b1, 24'h000000};
        tbl[2] = '{37,  70,  1'b0, 24'h000000};
        tbl[3] = '{639, 479, 1'b1, 24'hAA55CC};
        tbl[4] = '{640, 479, 1'b1, 24'h000000};
        tbl[5] = '{639, 480, 1'b1, 24'h000000};
`ifdef VGA_TILE_GRID_EN
        tbl[6] = '{64,  40,  1'b1, 24'hFFFFFF};
`else
        tbl[6] = '{64,  40,  1'b1, 24'h112233};
`endif

        // Reset hold, then release with a constant in-map pixel.
        for (int i = 0; i < 3; i++) cycle(1'b1, 37, 70, 1'b1, 1'b1, 1'b1);
        check("reset_rgb", {7'b0, vga_blank_z, red, green, blue}, 32'h0);
        check("reset_sync", {30'b0, hsync, vsync}, 32'h3);
        for (int i = 0; i < 4; i++) begin
            cycle(1'b0, 37, 70, 1'b1, 1'b1, 1'b1);
            check("drain", {7'b0, vga_blank_z, red, green, blue}, 32'h0);
        end
        cycle(1'b0, 37, 70, 1'b1, 1'b1, 1'b1);
        check("first_data", {7'b0, vga_blank_z, red, green, blue}, 32'h01FF8800);

        // Address timing for a single pixel.
        idle_cycle();
        cycle(1'b0, 37, 70, 1'b1, 1'b1, 1'b1);
        check("map_addr", 32'(map_addr), 32'd41);
        idle_cycle();
        idle_cycle();
        check("sprite_addr", 32'(sprite_addr), 32'hCC5);
        idle_cycle();
        idle_cycle();
        check("rgb_latency", {8'b0, red, green, blue}, 32'hFF8800);

        // Directed table: one pixel, then four idle cycles to reach its output.
        foreach (tbl[i]) begin
            cycle(1'b0, tbl[i].x, tbl[i].y, 1'b1, 1'b1, tbl[i].bz);
            for (int k = 0; k < 4; k++) idle_cycle();
            check($sformatf("table%0d", i), {7'b0, vga_blank_z, red, green, blue},
                  {7'b0, tbl[i].bz, tbl[i].rgb});
        end

        // Sync toggles reappear exactly at the output tap.
        for (int i = 0; i < 12; i++) begin
            hs_pat[i] = !(i == 2 || i == 3 || i == 7);
            vs_pat[i] = (i != 5);
        end
        for (int i = 0; i < 16; i++) begin
            if (i < 12) cycle(1'b0, 100, 100, hs_pat[i], vs_pat[i], 1'b1);
            else        cycle(1'b0, 100, 100, 1'b1, 1'b1, 1'b1);
            if (i >= 4) check("sync_delay", {30'b0, hsync, vsync},
                              {30'b0, hs_pat[i-4], vs_pat[i-4]});
        end

        // Mid-line reset drops in-flight pixels.
        for (int i = 0; i < 6; i++) cycle(1'b0, 32 * i + 3, 200, 1'b1, 1'b1, 1'b1);
        cycle(1'b1, 300, 200, 1'b1, 1'b1, 1'b1);
        check("midreset", {7'b0, vga_blank_z, red, green, blue}, 32'h0);
        for (int i = 0; i < 4; i++) begin
            cycle(1'b0, 300 + i, 200, 1'b1, 1'b1, 1'b1);
            check("midreset_drain", {7'b0, vga_blank_z, red, green, blue}, 32'h0);
        end

        // Randomized traffic checked against the per-pixel model.
        for (int i = 0; i < 2000; i++) begin
            cycle($urandom_range(0, 63) == 0,
                  ($urandom_range(0, 3) == 0) ? $urandom_range(0, 799) : $urandom_range(0, 639),
                  ($urandom_range(0, 3) == 0) ? $urandom_range(0, 524) : $urandom_range(0, 479),
                  $urandom_range(0, 7) != 0, $urandom_range(0, 15) != 0,
                  $urandom_range(0, 7) != 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
